// File: rtl/hand_manager_if.sv
// Deck <-> hand handshake.
//   draw  : request to the deck, 3'b001 while the hand is drawing
//   drawn : deck strobe, card is valid this cycle
//   card  : card delivered by the deck, {color[5:4], value[3:0]}
// master: hand side (drives draw); slave: deck side (drives drawn/card).
interface hand_manager_if;
  logic [2:0] draw;
  logic       drawn;
  logic [5:0] card;

  modport master (output draw, input drawn, input card);
  modport slave  (input draw, output drawn, output card);
endinterface

// File: rtl/hand_manager.sv
// Per-player hand store downstream of the card deck.
// Draws cards through the deck handshake, appends them to the hand, checks a
// chosen card against the top discard card and removes legal plays while
// keeping the order of the remaining cards.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_deal                 pulse: draw DEAL_N cards
//   i_draw_req             one-hot draw count (1/2/4), highest bit wins
//   deck                   draw/drawn/card handshake with the deck
//   i_play_valid/idx       pulse: play hand entry idx
//   i_top_card             top discard card (color = active color)
//   o_play_valid/card      pulse: legal card played, with the card
//   o_illegal              pulse: play rejected
//   o_has_legal            some held card is playable on i_top_card
//   i_rd_idx / o_rd_card   display read port (0 beyond count)
//   o_count, o_uno, o_empty, o_busy, o_overflow  status
module hand_manager #(
  parameter int MAX_CARDS = 32,
  parameter int IDX_W     = 5,
  parameter int DEAL_N    = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_deal,
  input  logic [2:0]       i_draw_req,
  hand_manager_if.master   deck,
  input  logic             i_play_valid,
  input  logic [IDX_W-1:0] i_play_idx,
  input  logic [5:0]       i_top_card,
  output logic             o_play_valid,
  output logic [5:0]       o_play_card,
  output logic             o_illegal,
  output logic             o_has_legal,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [5:0]       o_rd_card,
  output logic [IDX_W:0]   o_count,
  output logic             o_uno,
  output logic             o_empty,
  output logic             o_busy,
  output logic             o_overflow
);

  localparam int PEND_W = $clog2((DEAL_N > 4 ? DEAL_N : 4) + 1);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(MAX_CARDS);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CHECK, S_REMOVE} state_t;

  state_t              state, state_nxt;
  logic [5:0]          hand [MAX_CARDS];
  logic [IDX_W:0]      count;
  logic [PEND_W-1:0]   pending;
  logic [PEND_W-1:0]   req_n;
  logic [IDX_W-1:0]    ptr;
  logic [5:0]          card_q;
  logic                overflow;
  logic [IDX_W:0]      last;
  logic                shift_more;
  logic                check_legal;

  function automatic logic is_legal(input logic [5:0] c, input logic [5:0] top);
    return (c[3:0] != 4'd15) &&
           ((c[5:4] == top[5:4]) || (c[3:0] == top[3:0]) ||
            (c[3:0] == 4'd13) || (c[3:0] == 4'd14));
  endfunction

  assign req_n = i_draw_req[2] ? PEND_W'(4) :
                 i_draw_req[1] ? PEND_W'(2) : PEND_W'(1);

  // last is only meaningful in S_REMOVE, where count >= 1 is guaranteed
  assign last        = count - 1'b1;
  assign shift_more  = {1'b0, ptr} < last;
  assign check_legal = ({1'b0, ptr} < count) && is_legal(card_q, i_top_card);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_deal || (|i_draw_req)) state_nxt = S_DRAW;
        else if (i_play_valid)       state_nxt = S_CHECK;
      end
      S_DRAW:   if (deck.drawn && pending == PEND_W'(1)) state_nxt = S_IDLE;
      S_CHECK:  state_nxt = check_legal ? S_REMOVE : S_IDLE;
      S_REMOVE: if (!shift_more) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    deck.draw    = (state == S_DRAW) ? 3'b001 : 3'b000;
    o_play_valid = (state == S_CHECK) && check_legal;
    o_illegal    = (state == S_CHECK) && !check_legal;
    o_play_card  = o_play_valid ? card_q : '0;
    o_busy       = (state != S_IDLE);
  end

  // Hand datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < MAX_CARDS; i++) hand[i] <= '0;
      count    <= '0;
      pending  <= '0;
      ptr      <= '0;
      card_q   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_deal) begin
            pending <= PEND_W'(DEAL_N);
          end else if (|i_draw_req) begin
            pending <= req_n;
          end else if (i_play_valid) begin
            ptr    <= i_play_idx;
            card_q <= hand[i_play_idx];
          end
        end
        S_DRAW: begin
          if (deck.drawn) begin
            if (count < FULL) begin
              hand[count[IDX_W-1:0]] <= deck.card;
              count                  <= count + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
            pending <= pending - 1'b1;
          end
        end
        S_REMOVE: begin
          // Shift the tail down one slot per cycle; the final step clears
          // the vacated last entry (ptr == count-1 here).
          if (shift_more) begin
            hand[ptr] <= hand[ptr + 1'b1];
            ptr       <= ptr + 1'b1;
          end else begin
            hand[ptr] <= '0;
            count     <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_has_legal = 1'b0;
    for (int unsigned i = 0; i < MAX_CARDS; i++) begin
      if (((IDX_W+1)'(i) < count) && is_legal(hand[i], i_top_card))
        o_has_legal = 1'b1;
    end
  end

  assign o_rd_card  = ({1'b0, i_rd_idx} < count) ? hand[i_rd_idx] : '0;
  assign o_count    = count;
  assign o_uno      = (count == (IDX_W+1)'(1));
  assign o_empty    = (count == '0);
  assign o_overflow = overflow;

endmodule

// File: tb/tb_hand_manager.sv
// Directed bench for hand_manager: deal, legal/illegal plays with hand
// compaction, wild draw four, overflow when full, request priority and
// busy-time drops, and reset in the middle of a draw.
module tb_hand_manager;

  logic       clk = 1'b0;
  logic       rst, deal, play_valid;
  logic [2:0] draw_req;
  logic [4:0] play_idx, rd_idx;
  logic [5:0] top_card, play_card, rd_card;
  logic       o_play_valid, illegal, has_legal, uno, empty, busy, overflow;
  logic [5:0] count;

  int checks = 0;
  int errors = 0;

  hand_manager_if deck_if();

  hand_manager #(.MAX_CARDS(32), .IDX_W(5), .DEAL_N(7)) dut (
    .i_clk(clk), .i_rst(rst), .i_deal(deal), .i_draw_req(draw_req),
    .deck(deck_if.master),
    .i_play_valid(play_valid), .i_play_idx(play_idx), .i_top_card(top_card),
    .o_play_valid(o_play_valid), .o_play_card(play_card), .o_illegal(illegal),
    .o_has_legal(has_legal), .i_rd_idx(rd_idx), .o_rd_card(rd_card),
    .o_count(count), .o_uno(uno), .o_empty(empty), .o_busy(busy),
    .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic request(input logic d, input logic [2:0] r);
    deal = d;
    draw_req = r;
    tick();
    deal = 1'b0;
    draw_req = 3'b000;
  endtask

  task automatic feed(input logic [5:0] c);
    deck_if.drawn = 1'b1;
    deck_if.card  = c;
    tick();
    deck_if.drawn = 1'b0;
    deck_if.card  = '0;
  endtask

  task automatic play(input logic [4:0] idx);
    play_valid = 1'b1;
    play_idx   = idx;
    tick();
    play_valid = 1'b0;
    play_idx   = '0;
  endtask

  task automatic rd(input string tag, input logic [4:0] idx, input logic [5:0] exp);
    rd_idx = idx;
    #1;
    chk(tag, rd_card, exp);
  endtask

  logic [5:0] deal_cards [7];

  initial begin
    deal_cards = '{6'h05, 6'h39, 6'h2D, 6'h11, 6'h0C, 6'h2A, 6'h3E};
    rst = 1'b1; deal = 1'b0; draw_req = '0; play_valid = 1'b0; play_idx = '0;
    top_card = '0; rd_idx = '0;
    deck_if.drawn = 1'b0; deck_if.card = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_draw", deck_if.draw, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_pv", o_play_valid, 0);
    chk("rst_pcard", play_card, 0);
    chk("rst_has_legal", has_legal, 0);

    // Deal 7 cards, deliveries spaced 2 cycles apart
    request(1'b1, 3'b000);
    chk("deal_busy", busy, 1);
    for (int k = 0; k < 7; k++) begin
      chk("deal_draw_gap", deck_if.draw, 3'b001);
      tick();
      chk("deal_draw_pre", deck_if.draw, 3'b001);
      feed(deal_cards[k]);
    end
    chk("deal_draw_done", deck_if.draw, 0);
    chk("deal_count", count, 7);
    chk("deal_busy_done", busy, 0);
    for (int k = 0; k < 7; k++) rd("deal_rd", 5'(k), deal_cards[k]);
    rd("deal_rd_beyond", 5'd7, 6'h00);

    // Hand {red 5, blue 9, green wild}, top yellow 9
    do_reset();
    request(1'b0, 3'b010);
    feed(6'h05);
    feed(6'h39);
    request(1'b0, 3'b001);
    feed(6'h2D);
    chk("h3_count", count, 3);
    top_card = 6'h19;
    #1;
    chk("h3_has_legal", has_legal, 1);
    play(5'd0);
    chk("h3_illegal", illegal, 1);
    chk("h3_illegal_pv", o_play_valid, 0);
    tick();
    chk("h3_illegal_end", illegal, 0);
    chk("h3_count_kept", count, 3);
    chk("h3_idle", busy, 0);
    play(5'd1);
    chk("h3_pv", o_play_valid, 1);
    chk("h3_pcard", play_card, 6'h39);
    chk("h3_no_illegal", illegal, 0);
    tick();
    chk("h3_pv_end", o_play_valid, 0);
    chk("h3_busy1", busy, 1);
    tick();
    chk("h3_busy2", busy, 1);
    tick();
    chk("h3_busy_done", busy, 0);
    chk("h3_count_after", count, 2);
    rd("h3_rd0", 5'd0, 6'h05);
    rd("h3_rd1", 5'd1, 6'h2D);
    rd("h3_rd2", 5'd2, 6'h00);

    // Single wild draw four against red 7
    do_reset();
    request(1'b0, 3'b001);
    feed(6'h3E);
    top_card = 6'h07;
    #1;
    chk("w4_has_legal", has_legal, 1);
    chk("w4_uno", uno, 1);
    play(5'd0);
    chk("w4_pv", o_play_valid, 1);
    chk("w4_pcard", play_card, 6'h3E);
    tick();
    tick();
    chk("w4_empty", empty, 1);
    chk("w4_busy", busy, 0);
    chk("w4_has_legal_empty", has_legal, 0);
    // Index beyond count is illegal
    play(5'd5);
    chk("oob_illegal", illegal, 1);
    tick();
    // Invalid value never plays, even on matching color
    request(1'b0, 3'b001);
    feed(6'h1F);
    top_card = 6'h17;
    #1;
    chk("inv_has_legal", has_legal, 0);
    play(5'd0);
    chk("inv_illegal", illegal, 1);
    tick();
    chk("inv_count", count, 1);

    // Fill to 32, then four more cards overflow
    do_reset();
    for (int b = 0; b < 8; b++) begin
      request(1'b0, 3'b100);
      for (int j = 0; j < 4; j++) feed(6'(b * 4 + j));
    end
    chk("full_count", count, 32);
    chk("full_ovf0", overflow, 0);
    rd("full_rd31", 5'd31, 6'h1F);
    request(1'b0, 3'b100);
    feed(6'h3A);
    chk("ovf_set", overflow, 1);
    feed(6'h3A);
    feed(6'h3A);
    chk("ovf_draw_pre4", deck_if.draw, 3'b001);
    feed(6'h3A);
    chk("ovf_draw_done", deck_if.draw, 0);
    chk("ovf_count", count, 32);
    chk("ovf_sticky", overflow, 1);
    rd("ovf_rd31", 5'd31, 6'h1F);

    // Draw beats play in the same cycle; play during S_DRAW ignored
    do_reset();
    draw_req = 3'b010;
    play_valid = 1'b1;
    play_idx = 5'd0;
    tick();
    draw_req = '0;
    play_valid = 1'b0;
    chk("prio_draw", deck_if.draw, 3'b001);
    chk("prio_no_illegal", illegal, 0);
    play(5'd0);
    chk("busy_play_pv", o_play_valid, 0);
    chk("busy_play_ill", illegal, 0);
    feed(6'h05);
    feed(6'h06);
    chk("prio_count", count, 2);
    chk("prio_idle", busy, 0);
    chk("prio_no_ill_after", illegal, 0);

    // Reset in the middle of a 4-card draw
    do_reset();
    request(1'b0, 3'b100);
    feed(6'h01);
    chk("mid_count1", count, 1);
    do_reset();
    chk("mid_draw", deck_if.draw, 0);
    chk("mid_count", count, 0);
    chk("mid_busy", busy, 0);
    feed(6'h02);
    feed(6'h03);
    chk("mid_ignored", count, 0);
    rd("mid_rd0", 5'd0, 6'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
